// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and the requester packet layout for the CDB arbitration slice.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int ROB_TAG_W   = 5;
  localparam int CDB_DATA_W  = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] value;
  } cdb_req_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping,
// found by scanning a doubled copy of the request vector.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N);

  logic [2*N-1:0] w_req_dbl;

  assign w_req_dbl = {req, req};

  always_comb begin
    logic [PTR_W:0] j;
    logic [PTR_W:0] j_wrap;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = '0;
    j_wrap    = '0;
    for (int k = 0; k < N; k++) begin
      j      = {1'b0, ptr} + (PTR_W+1)'(k);
      j_wrap = (j >= N_EXT) ? (j - N_EXT) : j;
      if (!grant_any && w_req_dbl[j]) begin
        grant_any                 = 1'b1;
        grant_idx                 = j_wrap[PTR_W-1:0];
        grant[j_wrap[PTR_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// One-entry holding register per functional unit, round-robin pick of one held
// result per cycle, registered CDB broadcast; squash drops everything in flight.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int TAG_W   = ROB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_value,
  output logic [NUM_REQ-1:0]      hold_occ
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] r_hold_v;
  logic [TAG_W-1:0]   r_hold_tag [NUM_REQ];
  logic [DATA_W-1:0]  r_hold_val [NUM_REQ];
  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_cdb_valid;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_value;

  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_grant_any;
  logic [NUM_REQ-1:0] w_accept;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req       (r_hold_v),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  // Handshake: a result transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both high; valid without ready is held by the requester.
  // Ready is high when the slot is empty or being granted this cycle, and
  // low for all requesters during squash.
  assign req_ready = {NUM_REQ{~squash}} & (~r_hold_v | w_grant);
  assign w_accept  = req_valid & req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold_v <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_hold_tag[i] <= '0;
        r_hold_val[i] <= '0;
      end
    end else if (squash) begin
      r_hold_v <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_hold_v[i]   <= 1'b1;
          r_hold_tag[i] <= req_tag[i*TAG_W +: TAG_W];
          r_hold_val[i] <= req_value[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // Tag/value keep their last broadcast contents when no grant occurs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
      r_rr_ptr    <= '0;
    end else if (squash) begin
      r_cdb_valid <= 1'b0;
    end else if (w_grant_any) begin
      r_cdb_valid <= 1'b1;
      r_cdb_tag   <= r_hold_tag[w_grant_idx];
      r_cdb_value <= r_hold_val[w_grant_idx];
      r_rr_ptr    <= (w_grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : (w_grant_idx + 1'b1);
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_value = r_cdb_value;
  assign hold_occ  = r_hold_v;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a per-cycle reference model and
// hand-computed literal expectations.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  logic squash;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_value;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_value;
  logic [N-1:0]    hold_occ;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_value (req_value),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .hold_occ  (hold_occ)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] val);
    req_valid[i]          = v;
    req_tag[i*TW +: TW]   = t;
    req_value[i*DW +: DW] = val;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_tag   = '0;
    req_value = '0;
  endtask

  // ---------------- reference model ----------------
  bit            m_hold_v   [N];
  logic [TW-1:0] m_hold_tag [N];
  logic [DW-1:0] m_hold_val [N];
  int            m_ptr;
  bit            m_cdb_v;
  logic [TW-1:0] m_cdb_tag;
  logic [DW-1:0] m_cdb_val;
  int            mg;

  // Round-robin rule: first held entry at or after the pointer, wrapping.
  function automatic int pick();
    for (int off = 0; off < N; off++)
      if (m_hold_v[(m_ptr + off) % N]) return (m_ptr + off) % N;
    return -1;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_hold_v[i] = 1'b0;
        m_hold_tag[i] = '0;
        m_hold_val[i] = '0;
      end
      m_ptr = 0; m_cdb_v = 1'b0; m_cdb_tag = '0; m_cdb_val = '0;
    end else if (squash) begin
      for (int i = 0; i < N; i++) m_hold_v[i] = 1'b0;
      m_cdb_v = 1'b0;
    end else begin
      mg = pick();
      if (mg >= 0) begin
        m_cdb_v   = 1'b1;
        m_cdb_tag = m_hold_tag[mg];
        m_cdb_val = m_hold_val[mg];
        m_hold_v[mg] = 1'b0;
        m_ptr = (mg + 1) % N;
      end else begin
        m_cdb_v = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !m_hold_v[i]) begin
          m_hold_v[i]   = 1'b1;
          m_hold_tag[i] = req_tag[i*TW +: TW];
          m_hold_val[i] = req_value[i*DW +: DW];
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [N-1:0] c_rdy;
  logic [N-1:0] c_occ;
  int           c_g;

  always @(negedge clock) begin
    if (chk_en) begin
      c_g = pick();
      for (int i = 0; i < N; i++) begin
        c_occ[i] = m_hold_v[i];
        c_rdy[i] = !squash && (!m_hold_v[i] || c_g == i);
      end
      check("m_cdb_valid", cdb_valid, m_cdb_v);
      check("m_cdb_tag",   cdb_tag,   m_cdb_tag);
      check("m_cdb_value", cdb_value, m_cdb_val);
      check("m_hold_occ",  hold_occ,  c_occ);
      check("m_req_ready", req_ready, c_rdy);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] exp_t;
  int seen_at;
  int seen_cnt;

  initial begin
    reset = 1'b0;
    squash = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clock);
    step();
    check("rst_cdb_valid", cdb_valid, 1'b0);
    check("rst_cdb_tag",   cdb_tag,   '0);
    check("rst_cdb_value", cdb_value, '0);
    check("rst_hold_occ",  hold_occ,  4'b0000);
    check("rst_req_ready", req_ready, 4'b1111);
    reset = 1'b1;
    chk_en = 1'b1;

    // Single result on requester 2: visible exactly two edges later.
    set_req(2, 1'b1, 5'd7, 32'hDEAD);
    check("t1_ready0", req_ready, 4'b1111);
    step();
    clear_reqs();
    check("t1_occ",    hold_occ,  4'b0100);
    check("t1_early",  cdb_valid, 1'b0);
    check("t1_ready1", req_ready, 4'b1111);
    step();
    check("t1_valid", cdb_valid, 1'b1);
    check("t1_tag",   cdb_tag,   5'd7);
    check("t1_value", cdb_value, 32'hDEAD);
    check("t1_ready2", req_ready, 4'b1111);

    // Pointer is 3: requester 3 wins, then wrap lets requester 0 go before 3.
    set_req(3, 1'b1, 5'd11, 32'h1100);
    step();
    set_req(0, 1'b1, 5'd20, 32'h2000);
    set_req(3, 1'b1, 5'd21, 32'h2100);
    step();
    clear_reqs();
    check("t6_tag11", cdb_tag, 5'd11);
    check("t6_occ",   hold_occ, 4'b1001);
    step();
    check("t6_wrap_valid", cdb_valid, 1'b1);
    check("t6_wrap_tag",   cdb_tag,   5'd20);
    step();
    check("t6_tag21", cdb_tag, 5'd21);
    check("t6_empty", hold_occ, 4'b0000);

    // All four requesters streaming tags 1..4 from pointer 0.
    for (int r = 0; r < 3; r++)
      for (int t = 1; t <= 4; t++)
        if (exp_q.size() < 10) exp_q.push_back(TW'(t));
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, TW'(i + 1), 32'hA0 + i);
      if (k == 0) check("t2_ready_k0", req_ready, 4'b1111);
      else        check("t2_ready_pulse", req_ready, 4'b0001 << ((k - 1) % 4));
      if (k >= 2) begin
        if (cdb_valid && exp_q.size() > 0) begin
          exp_t = exp_q.pop_front();
          check("t2_order", cdb_tag, exp_t);
        end else begin
          check("t2_bubble", cdb_valid, 1'b1);
        end
      end
      step();
    end
    clear_reqs();
    repeat (6) step();

    // Requester 1 holds tag 9 while requester 0 streams.
    seen_at = -1;
    seen_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      clear_reqs();
      if (k < 10) set_req(0, 1'b1, TW'(16 + k), DW'(k));
      if (k == 0) set_req(1, 1'b1, 5'd9, 32'h99);
      if (cdb_valid && cdb_tag == 5'd9 && cdb_value == 32'h99) begin
        if (seen_at < 0) seen_at = k;
        seen_cnt++;
      end
      step();
    end
    clear_reqs();
    check("t3_seen_once", seen_cnt, 1);
    check("t3_within_bound", (seen_at >= 2 && seen_at <= 5), 1'b1);
    repeat (6) step();

    // Fill all slots, broadcast one, then squash the remaining three.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, TW'(24 + i), 32'hC0 + i);
    step();
    clear_reqs();
    check("t4_full", hold_occ, 4'b1111);
    step();
    squash = 1'b1;
    #1;
    check("t4_sq_ready", req_ready, 4'b0000);
    check("t4_sq_occ3",  $countones(hold_occ), 3);
    check("t4_sq_cdbv",  cdb_valid, 1'b1);
    step();
    squash = 1'b0;
    check("t4_post_valid", cdb_valid, 1'b0);
    check("t4_post_occ",   hold_occ,  4'b0000);
    for (int k = 0; k < 5; k++) begin
      check("t4_no_wrongpath", cdb_valid, 1'b0);
      step();
    end

    // Asynchronous reset between edges with results in flight.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, TW'(1 + i), 32'hB0 + i);
    step();
    step();
    #1;
    reset = 1'b0;
    #1;
    check("t5_async_valid", cdb_valid, 1'b0);
    check("t5_async_occ",   hold_occ,  4'b0000);
    clear_reqs();
    step();
    reset = 1'b1;
    set_req(1, 1'b1, 5'd13, 32'h1313);
    set_req(2, 1'b1, 5'd14, 32'h1414);
    step();
    clear_reqs();
    check("t5_occ", hold_occ, 4'b0110);
    step();
    check("t5_first_tag", cdb_tag, 5'd13);
    check("t5_first_val", cdb_value, 32'h1313);
    step();
    check("t5_second_tag", cdb_tag, 5'd14);
    check("t5_second_v",   cdb_valid, 1'b1);
    step();
    check("t5_idle", cdb_valid, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
